demux_rr_sched: RTL and testbench

Round-robin, credit-based scheduler for the 1:4 demultiplexer path. It accepts a single valid/ready input stream and issues each beat to one of four outputs, selecting the next output in rotation that still has credit. It then drives the sel1/sel0 selects and a one-hot valid for exactly one cycle per beat. It sits between a single producer and four consumers that return credits as they drain their own buffers.

---
 rtl/demux_sched_pkg.sv | 42 ++++
 rtl/demux_credit_ctr.sv | 61 ++++++
 rtl/demux_rr_sched.sv | 100 ++++++++++
 tb/tb_demux_rr_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// -----------------------------------------------------------------------------
// demux_sched_pkg
// Shared definitions for the 1:4 demux round-robin credit scheduler.
//   NUM_OUT   : number of demux outputs
//   SEL_W     : width of an output index
//   CNT_W     : width of a per-output credit counter (holds 0..15)
//   out_idx_t : output index type
//   rr_pick   : round-robin search helper returning {found, idx}
// -----------------------------------------------------------------------------
package demux_sched_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 4;

    typedef logic [SEL_W-1:0] out_idx_t;

    typedef struct packed {
        logic     found;
        out_idx_t idx;
    } rr_pick_t;

    // First eligible index scanning ptr, ptr+1, ... (mod NUM_OUT).
    // The loop runs from the farthest offset down so the nearest eligible
    // candidate is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(input out_idx_t ptr,
                                         input logic [NUM_OUT-1:0] eligible);
        rr_pick_t r;
        out_idx_t cand;
        r.found = 1'b0;
        r.idx   = ptr;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            cand = ptr + out_idx_t'(i);
            if (eligible[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_credit_ctr.sv
// -----------------------------------------------------------------------------
// demux_credit_ctr
// One per-output credit counter. Resets full (CREDITS), decrements when a beat
// is issued to this output, increments on a credit return, saturates at
// CREDITS and reports an over-return as a single-cycle overflow pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   dec        : a beat was granted to this output this cycle
//   inc        : a credit was returned to this output this cycle
//   eligible   : counter is non-zero (output may be granted)
//   overflow   : credit returned while already full (and no grant offset it)
// -----------------------------------------------------------------------------
module demux_credit_ctr
    import demux_sched_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dec,
    input  logic inc,
    output logic eligible,
    output logic overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // A grant and a return in the same cycle cancel: count unchanged and the
    // return is not treated as an over-return even when the counter is full.
    always_comb begin
        cnt_nxt = cnt;
        case ({dec, inc})
            2'b10: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            2'b01: begin
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_MAX;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign eligible = (cnt != '0);
    assign overflow = inc & ~dec & (cnt == CNT_MAX);

endmodule

// File: rtl/demux_rr_sched.sv
// -----------------------------------------------------------------------------
// demux_rr_sched
// Round-robin, credit-based scheduler for the 1:4 demux path. Accepts one
// valid/ready stream and issues each beat to the next output (in rotation from
// ptr) that still holds credit. The chosen beat appears one cycle later as a
// one-hot out_valid pulse with the payload and the {sel1,sel0} index.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : producer has a beat
//   in_data    : beat payload (WIDTH bits)
//   in_ready   : some output has credit; derived from registered state only
//   cred_ret   : per-output credit return pulses
//   out_valid  : one-hot pulse, bit k = beat for output k
//   out_data   : registered payload, holds when no beat is issued
//   sel0, sel1 : registered output index, holds when no beat is issued
//   cred_err   : sticky, set by a credit returned to a full counter
// -----------------------------------------------------------------------------
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    input  logic [NUM_OUT-1:0] cred_ret,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               sel0,
    output logic               sel1,
    output logic               cred_err
);

    out_idx_t           ptr;
    out_idx_t           sel_q;
    rr_pick_t           pick;
    logic               accept;
    logic [NUM_OUT-1:0] eligible;
    logic [NUM_OUT-1:0] grant_oh;
    logic [NUM_OUT-1:0] dec;
    logic [NUM_OUT-1:0] overflow;

    // Grant search depends only on ptr and the counters, so in_ready has no
    // path from in_valid.
    always_comb begin
        pick = rr_pick(ptr, eligible);
    end

    assign in_ready = pick.found;
    assign accept   = in_valid & in_ready;

    always_comb begin
        grant_oh            = '0;
        grant_oh[pick.idx]  = 1'b1;
    end

    assign dec = accept ? grant_oh : '0;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ctr
        demux_credit_ctr #(
            .CREDITS (CREDITS)
        ) u_ctr (
            .clk      (clk),
            .rst_n    (rst_n),
            .dec      (dec[k]),
            .inc      (cred_ret[k]),
            .eligible (eligible[k]),
            .overflow (overflow[k])
        );
    end

    // ptr advances past the granted output; data/sel hold between beats so
    // downstream muxes keep a stable select while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            out_valid <= '0;
            out_data  <= '0;
            sel_q     <= '0;
            cred_err  <= 1'b0;
        end else begin
            cred_err <= cred_err | (|overflow);
            if (accept) begin
                ptr       <= pick.idx + 2'd1;
                out_valid <= grant_oh;
                out_data  <= in_data;
                sel_q     <= pick.idx;
            end else begin
                out_valid <= '0;
            end
        end
    end

    assign sel1 = sel_q[1];
    assign sel0 = sel_q[0];

endmodule

// File: tb/tb_demux_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_demux_rr_sched
// Directed stimulus with a behavioural scheduler model; every cycle the DUT
// outputs are compared against the model, and a set of hand-computed literal
// expectations pins the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_demux_rr_sched;

    localparam int WIDTH   = 8;
    localparam int CREDITS = 4;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic [3:0]       cred_ret = '0;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic             sel0;
    logic             sel1;
    logic             cred_err;

    int vecs = 0;
    int errs = 0;

    demux_rr_sched #(
        .WIDTH   (WIDTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cred_ret  (cred_ret),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel0      (sel0),
        .sel1      (sel1),
        .cred_err  (cred_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0][7:0]  cnt;
        logic [1:0]       ptr;
        logic [3:0]       vld;
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
        logic             err;
    } mst_t;

    mst_t m;

    function automatic mst_t rst_state();
        mst_t s;
        s = '0;
        for (int k = 0; k < 4; k++) s.cnt[k] = 8'(CREDITS);
        return s;
    endfunction

    function automatic logic m_ready(input mst_t s);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 4; k++) if (s.cnt[k] != 8'd0) r = 1'b1;
        return r;
    endfunction

    function automatic mst_t step(input mst_t s, input logic v,
                                  input logic [WIDTH-1:0] d, input logic [3:0] ret);
        mst_t n;
        int   g;
        logic take;
        n = s;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (int'(s.ptr) + i) % 4;
            if (g < 0 && s.cnt[k] != 8'd0) g = k;
        end
        n.vld = '0;
        for (int k = 0; k < 4; k++) begin
            take = v && (g == k);
            if (take && ret[k]) begin
                n.cnt[k] = s.cnt[k];
            end else if (take) begin
                n.cnt[k] = s.cnt[k] - 8'd1;
            end else if (ret[k]) begin
                if (s.cnt[k] == 8'(CREDITS)) n.err = 1'b1;
                else                          n.cnt[k] = s.cnt[k] + 8'd1;
            end
        end
        if (v && g >= 0) begin
            n.vld[g] = 1'b1;
            n.data   = d;
            n.sel    = 2'(g);
            n.ptr    = 2'((g + 1) % 4);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= rst_state();
        else        m <= step(m, in_valid, in_data, cred_ret);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",  32'(in_ready),     32'(m_ready(m)));
        chk("out_valid", 32'(out_valid),    32'(m.vld));
        chk("out_data",  32'(out_data),     32'(m.data));
        chk("sel",       32'({sel1, sel0}), 32'(m.sel));
        chk("cred_err",  32'(cred_err),     32'(m.err));
    endtask

    // One clock: drive at negedge, check just after the rising edge.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic [3:0] ret);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        cred_ret = ret;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cred_ret = '0;
        @(posedge clk);
        #1;
        compare_all();
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_cred_err",  32'(cred_err),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_vld [7];

    initial begin
        // --- rotation 0,1,2,3 after reset ---
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, WIDTH'(8'h10 + i), 4'b0000);
            chk("rot_vld",  32'(out_valid),    32'(1) << i);
            chk("rot_sel",  32'({sel1, sel0}), 32'(i));
            chk("rot_data", 32'(out_data),     32'(8'h10 + i));
        end

        // --- drain all credits, then a single return to output 2 ---
        for (int i = 0; i < 12; i++) cyc(1'b1, WIDTH'(8'h14 + i), 4'b0000);
        chk("drain_ready", 32'(in_ready), 32'h0);
        cyc(1'b0, 8'h00, 4'b0100);
        chk("ret2_ready", 32'(in_ready), 32'h1);
        cyc(1'b1, 8'h55, 4'b0000);
        chk("ret2_vld",   32'(out_valid), 32'h4);
        chk("ret2_ready2", 32'(in_ready), 32'h0);
        cyc(1'b1, 8'h66, 4'b0000);
        chk("stall_vld",  32'(out_valid), 32'h0);
        chk("stall_data", 32'(out_data),  32'h55);

        // --- output 1 exhausted: grants skip it until its credit returns ---
        cyc(1'b0, 8'h00, 4'b1101);
        cyc(1'b0, 8'h00, 4'b1101);
        exp_vld = '{4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, WIDTH'(8'h30 + i), (i == 5) ? 4'b0010 : 4'b0000);
            chk("skip1_vld", 32'(out_valid), 32'(exp_vld[i]));
        end

        // --- accept to 0 with simultaneous return to 0 ---
        do_reset();
        cyc(1'b1, 8'hA0, 4'b0001);
        chk("cancel_vld", 32'(out_valid), 32'h1);
        chk("cancel_err", 32'(cred_err),  32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(8'hA1 + i), 4'b0000);
        cyc(1'b1, 8'hA4, 4'b0000);
        chk("cancel_next0", 32'(out_valid), 32'h1);
        // counters now 3,3,3,3: eleven more beats leave credit, the twelfth empties all
        for (int i = 0; i < 11; i++) cyc(1'b1, WIDTH'(8'hB0 + i), 4'b0000);
        chk("cancel_ready11", 32'(in_ready), 32'h1);
        cyc(1'b1, 8'hBB, 4'b0000);
        chk("cancel_ready12", 32'(in_ready), 32'h0);

        // --- over-return straight after reset ---
        do_reset();
        cyc(1'b0, 8'h00, 4'b1111);
        chk("ovr_err", 32'(cred_err), 32'h1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 4'b0000);
        chk("ovr_sticky", 32'(cred_err), 32'h1);
        for (int i = 0; i < 15; i++) cyc(1'b1, WIDTH'(8'hC0 + i), 4'b0000);
        chk("ovr_cnt15", 32'(in_ready), 32'h1);
        cyc(1'b1, 8'hCF, 4'b0000);
        chk("ovr_cnt16", 32'(in_ready), 32'h0);
        do_reset();

        // --- asynchronous reset mid-stream while out_valid = 0100 ---
        for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(8'hD0 + i), 4'b0000);
        chk("mid_vld", 32'(out_valid), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_vld",  32'(out_valid),    32'h0);
        chk("async_data", 32'(out_data),     32'h0);
        chk("async_sel",  32'({sel1, sel0}), 32'h0);
        compare_all();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'hE0, 4'b0000);
        chk("post_rst_vld",  32'(out_valid), 32'h1);
        chk("post_rst_data", 32'(out_data),  32'hE0);
        cyc(1'b0, 8'h00, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
